// File: rtl/cheshire_chip_rst_seq_if.sv
// Pad-ring side signal bundle of the chip reset/boot sequencer.
// master drives lock/straps/requests, slave (the sequencer) drives reset and status.
interface cheshire_chip_rst_seq_if;
  logic       pll_lock_i;
  logic [1:0] boot_mode_pad_i;
  logic       test_mode_i;
  logic       sw_rst_req_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic       soc_rst_no;
  logic [1:0] boot_mode_o;
  logic       boot_valid_o;
  logic [1:0] rst_cause_o;
  logic [2:0] state_o;

  modport master (
    output pll_lock_i, boot_mode_pad_i, test_mode_i, sw_rst_req_i, wdt_en_i, wdt_kick_i,
    input  soc_rst_no, boot_mode_o, boot_valid_o, rst_cause_o, state_o
  );

  modport slave (
    input  pll_lock_i, boot_mode_pad_i, test_mode_i, sw_rst_req_i, wdt_en_i, wdt_kick_i,
    output soc_rst_no, boot_mode_o, boot_valid_o, rst_cause_o, state_o
  );
endinterface

// File: rtl/cheshire_chip_rst_seq.sv
// Chip reset/boot sequencer: PLL lock wait, settle, boot-strap sample, SoC release, re-sequencing.
// Watchdog reset path is present only when CHESHIRE_RSTSEQ_WDT_EN is defined.
module cheshire_chip_rst_seq #(
  parameter int unsigned SettleCycles = 1024,
  parameter int unsigned HoldCycles   = 16,
  parameter int unsigned WdtCycles    = 65536,
  parameter int unsigned CntWidth     = $clog2(
    (((SettleCycles > HoldCycles) ? SettleCycles : HoldCycles) > WdtCycles
      ? ((SettleCycles > HoldCycles) ? SettleCycles : HoldCycles)
      : WdtCycles) + 1)
) (
  input logic                   clk_i,
  input logic                   rst_i,
  cheshire_chip_rst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    SAMPLE    = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_e;

  localparam logic [1:0] CausePor  = 2'd0;
  localparam logic [1:0] CauseLock = 2'd1;
  localparam logic [1:0] CauseSw   = 2'd2;
  localparam logic [1:0] CauseWdt  = 2'd3;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]          lock_sync_q, lock_sync_d;
  logic [1:0]          mode_sync1_q, mode_sync1_d;
  logic [1:0]          mode_sync2_q, mode_sync2_d;
  logic                soc_rst_n_q, soc_rst_n_d;
  logic                boot_valid_q, boot_valid_d;
  logic [1:0]          boot_mode_q, boot_mode_d;
  logic [1:0]          rst_cause_q, rst_cause_d;
  logic                lock_s;
  logic [1:0]          mode_s;
  logic                wdt_expire;

  assign lock_s  = lock_sync_q[1];
  assign mode_s  = mode_sync2_q;
  assign cnt_inc = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef CHESHIRE_RSTSEQ_WDT_EN
  // A kick in the expiry cycle rescues the SoC.
  assign wdt_expire = bus.wdt_en_i && !bus.wdt_kick_i
                   && (cnt_q == CntWidth'(WdtCycles - 1));
`else
  logic unused_wdt;
  assign unused_wdt = bus.wdt_en_i ^ bus.wdt_kick_i;
  assign wdt_expire = 1'b0;
`endif

  always_comb begin
    lock_sync_d  = {lock_sync_q[0], bus.pll_lock_i};
    mode_sync1_d = bus.boot_mode_pad_i;
    mode_sync2_d = mode_sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    soc_rst_n_d  = soc_rst_n_q;
    boot_valid_d = boot_valid_q;
    boot_mode_d  = boot_mode_q;
    rst_cause_d  = rst_cause_q;

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_inc;
        if (bus.test_mode_i || (cnt_q == CntWidth'(SettleCycles - 1))) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        boot_mode_d  = mode_s;
        soc_rst_n_d  = 1'b1;
        boot_valid_d = 1'b1;
        cnt_d        = '0;
        state_d      = RUN;
      end
      RUN: begin
`ifdef CHESHIRE_RSTSEQ_WDT_EN
        if (!bus.wdt_en_i || bus.wdt_kick_i) cnt_d = '0;
        else                                 cnt_d = cnt_inc;
`else
        cnt_d = '0;
`endif
        if (wdt_expire || bus.sw_rst_req_i) begin
          state_d      = HOLD;
          cnt_d        = '0;
          soc_rst_n_d  = 1'b0;
          boot_valid_d = 1'b0;
          rst_cause_d  = wdt_expire ? CauseWdt : CauseSw;
        end
      end
      HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_q == CntWidth'(HoldCycles - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d      = WAIT_LOCK;
        cnt_d        = '0;
        soc_rst_n_d  = 1'b0;
        boot_valid_d = 1'b0;
      end
    endcase

    // Lock loss outranks every other exit and restarts from the lock wait.
    if (!lock_s && (state_q != WAIT_LOCK)) begin
      state_d      = WAIT_LOCK;
      cnt_d        = '0;
      soc_rst_n_d  = 1'b0;
      boot_valid_d = 1'b0;
      rst_cause_d  = CauseLock;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lock_sync_q  <= '0;
      mode_sync1_q <= '0;
      mode_sync2_q <= '0;
      soc_rst_n_q  <= 1'b0;
      boot_valid_q <= 1'b0;
      boot_mode_q  <= '0;
      rst_cause_q  <= CausePor;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_sync_q  <= lock_sync_d;
      mode_sync1_q <= mode_sync1_d;
      mode_sync2_q <= mode_sync2_d;
      soc_rst_n_q  <= soc_rst_n_d;
      boot_valid_q <= boot_valid_d;
      boot_mode_q  <= boot_mode_d;
      rst_cause_q  <= rst_cause_d;
    end
  end

  assign bus.soc_rst_no   = soc_rst_n_q;
  assign bus.boot_valid_o = boot_valid_q;
  assign bus.boot_mode_o  = boot_mode_q;
  assign bus.rst_cause_o  = rst_cause_q;
  assign bus.state_o      = state_q;

endmodule
